stopwatch_ctrl: RTL and testbench

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

---
 rtl/stopwatch_ctrl.sv | 146 ++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: three debounced push-buttons drive a four-state FSM
// (IDLE/RUN/PAUSE/LAP) plus the tick prescaler and clear pulse for the datapath.
module stopwatch_ctrl #(
   parameter int DEBOUNCE_CYCLES = 10000000,
   parameter int TICK_DIV        = 500000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       key_start_pause,
   input  logic       key_display_stop,
   input  logic       key_clear,
   output logic [1:0] state,
   output logic       count_en,
   output logic       tick,
   output logic       display_live,
   output logic       clear,
   output logic       led_run,
   output logic       led_disp
);

   localparam logic [1:0] ST_IDLE  = 2'b00;
   localparam logic [1:0] ST_RUN   = 2'b01;
   localparam logic [1:0] ST_PAUSE = 2'b10;
   localparam logic [1:0] ST_LAP   = 2'b11;

   localparam int K_START = 0;
   localparam int K_DISP  = 1;
   localparam int K_CLR   = 2;

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int SET_W = $clog2(DEBOUNCE_CYCLES + 3);
   localparam int PRE_W = $clog2(TICK_DIV + 1);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [SET_W-1:0] SET_MAX = SET_W'(DEBOUNCE_CYCLES + 2);
   localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

   logic [2:0]       keys;
   logic [2:0]       sync1;
   logic [2:0]       sync2;
   logic [2:0]       deb;
   logic [2:0]       deb_prev;
   logic [2:0]       armed;
   logic [2:0]       press;
   logic [CNT_W-1:0] cnt [3];
   logic [SET_W-1:0] settle;
   logic             settle_done;
   logic [PRE_W-1:0] presc;
   logic [1:0]       nxt;
   logic             counting;
   logic             nxt_counting;

   assign keys        = {key_clear, key_display_stop, key_start_pause};
   assign settle_done = (settle == SET_MAX);

   // A key is armed only once it has been seen released after a full debounce
   // window following reset, so a key held through reset cannot fire on release.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1    <= '1;
         sync2    <= '1;
         deb      <= '1;
         deb_prev <= '1;
         armed    <= '0;
         press    <= '0;
         settle   <= '0;
         for (int i = 0; i < 3; i++) cnt[i] <= '0;
      end else begin
         sync1    <= keys;
         sync2    <= sync1;
         deb_prev <= deb;
         if (!settle_done) settle <= settle + 1'b1;
         for (int i = 0; i < 3; i++) begin
            if (sync2[i] != deb[i]) begin
               if (cnt[i] == CNT_MAX) begin
                  deb[i] <= ~deb[i];
                  cnt[i] <= '0;
               end else begin
                  cnt[i] <= cnt[i] + 1'b1;
               end
            end else begin
               cnt[i] <= '0;
            end
            armed[i] <= armed[i] | (settle_done & deb[i] & sync2[i]);
            press[i] <= armed[i] & deb_prev[i] & ~deb[i];
         end
      end
   end

   // Priority clear > start > display; losing presses are simply dropped.
   always_comb begin
      nxt = state;
      if (press[K_CLR]) begin
         nxt = ST_IDLE;
      end else if (press[K_START]) begin
         case (state)
            ST_IDLE:  nxt = ST_RUN;
            ST_RUN:   nxt = ST_PAUSE;
            ST_LAP:   nxt = ST_PAUSE;
            default:  nxt = ST_RUN;
         endcase
      end else if (press[K_DISP]) begin
         case (state)
            ST_RUN:   nxt = ST_LAP;
            ST_LAP:   nxt = ST_RUN;
            default:  nxt = state;
         endcase
      end
   end

   assign counting     = (state == ST_RUN) || (state == ST_LAP);
   assign nxt_counting = (nxt == ST_RUN) || (nxt == ST_LAP);

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= ST_IDLE;
         count_en     <= 1'b0;
         display_live <= 1'b1;
         led_run      <= 1'b0;
         led_disp     <= 1'b1;
         clear        <= 1'b0;
         tick         <= 1'b0;
         presc        <= '0;
      end else begin
         state        <= nxt;
         count_en     <= nxt_counting;
         display_live <= (nxt != ST_LAP);
         led_run      <= nxt_counting;
         led_disp     <= (nxt != ST_LAP);
         clear        <= press[K_CLR];
         tick         <= 1'b0;
         // Prescaler holds through PAUSE so resume keeps the tick phase.
         if (state == ST_IDLE || nxt == ST_IDLE) begin
            presc <= '0;
         end else if (counting) begin
            if (presc == PRE_MAX) begin
               presc <= '0;
               tick  <= 1'b1;
            end else begin
               presc <= presc + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with DEBOUNCE_CYCLES=4, TICK_DIV=5;
// inputs change and outputs are sampled on the falling clock edge.
module tb_stopwatch_ctrl;

   logic       clk;
   logic       reset;
   logic       ks;
   logic       kd;
   logic       kc;
   logic [1:0] state;
   logic       count_en;
   logic       tick;
   logic       display_live;
   logic       clear;
   logic       led_run;
   logic       led_disp;

   int n_cmp = 0;
   int n_bad = 0;
   int n;
   int ticks;
   int clears;

   stopwatch_ctrl #(.DEBOUNCE_CYCLES(4), .TICK_DIV(5)) dut (
      .clk              (clk),
      .reset            (reset),
      .key_start_pause  (ks),
      .key_display_stop (kd),
      .key_clear        (kc),
      .state            (state),
      .count_en         (count_en),
      .tick             (tick),
      .display_live     (display_live),
      .clear            (clear),
      .led_run          (led_run),
      .led_disp         (led_disp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog expired");
   end

   task automatic cyc(input int k);
      repeat (k) @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
      end
   endtask

   // Counts falling edges until tick is seen high; -1 if it never comes.
   task automatic wait_tick(output int gap);
      gap = -1;
      for (int i = 1; i <= 20; i++) begin
         cyc(1);
         if (tick === 1'b1) begin
            gap = i;
            break;
         end
      end
   endtask

   initial begin
      reset = 1'b1;
      ks = 1'b1;
      kd = 1'b1;
      kc = 1'b1;
      cyc(3);
      check("rst_state", 32'(state), 0);
      check("rst_count_en", 32'(count_en), 0);
      check("rst_tick", 32'(tick), 0);
      check("rst_clear", 32'(clear), 0);
      check("rst_display_live", 32'(display_live), 1);
      check("rst_led_run", 32'(led_run), 0);
      check("rst_led_disp", 32'(led_disp), 1);
      reset = 1'b0;
      cyc(10);

      // Clean start press: state changes on the 8th edge after first low sample.
      ks = 1'b0;
      fork begin cyc(10); ks = 1'b1; end join_none
      cyc(7);
      check("start_edge7_state", 32'(state), 0);
      cyc(1);
      check("start_edge8_state", 32'(state), 1);
      check("start_count_en", 32'(count_en), 1);
      check("start_led_run", 32'(led_run), 1);
      check("start_display_live", 32'(display_live), 1);
      wait_tick(n);
      check("first_tick_gap", 32'(n), 5);
      cyc(1);
      check("tick_one_cycle", 32'(tick), 0);
      wait_tick(n);
      check("second_tick_gap", 32'(n), 4);

      // Three-cycle glitch on start: no event, cadence untouched.
      ks = 1'b0;
      cyc(3);
      ks = 1'b1;
      wait_tick(n);
      check("glitch_tick_gap", 32'(n), 2);
      cyc(8);
      check("glitch_state", 32'(state), 1);
      wait_tick(n);
      check("glitch_tick_gap2", 32'(n), 2);

      // Display press RUN->LAP then LAP->RUN.
      kd = 1'b0;
      fork begin cyc(10); kd = 1'b1; end join_none
      cyc(7);
      check("lap_edge7_state", 32'(state), 1);
      cyc(1);
      check("lap_state", 32'(state), 3);
      check("lap_display_live", 32'(display_live), 0);
      check("lap_led_disp", 32'(led_disp), 0);
      check("lap_count_en", 32'(count_en), 1);
      wait_tick(n);
      check("lap_tick_gap", 32'(n), 2);
      wait_tick(n);
      check("lap_tick_gap2", 32'(n), 5);
      wait_tick(n);
      check("lap_tick_gap3", 32'(n), 5);
      kd = 1'b0;
      fork begin cyc(10); kd = 1'b1; end join_none
      cyc(8);
      check("unlap_state", 32'(state), 1);
      check("unlap_display_live", 32'(display_live), 1);
      check("unlap_led_disp", 32'(led_disp), 1);
      wait_tick(n);
      check("unlap_tick_gap", 32'(n), 2);

      // Pause with prescaler at 2, then resume: next tick 3 cycles later.
      cyc(4);
      ks = 1'b0;
      fork begin cyc(10); ks = 1'b1; end join_none
      cyc(8);
      check("pause_state", 32'(state), 2);
      check("pause_count_en", 32'(count_en), 0);
      check("pause_presc", 32'(dut.presc), 2);
      ticks = 0;
      for (int i = 0; i < 12; i++) begin
         cyc(1);
         if (tick === 1'b1) ticks++;
      end
      check("pause_no_tick", 32'(ticks), 0);
      check("pause_presc_held", 32'(dut.presc), 2);
      check("pause_state_held", 32'(state), 2);
      ks = 1'b0;
      fork begin cyc(10); ks = 1'b1; end join_none
      cyc(8);
      check("resume_state", 32'(state), 1);
      check("resume_presc", 32'(dut.presc), 2);
      wait_tick(n);
      check("resume_tick_gap", 32'(n), 3);

      // Start and clear together: clear wins, start is discarded.
      ks = 1'b0;
      kc = 1'b0;
      fork begin cyc(10); ks = 1'b1; kc = 1'b1; end join_none
      cyc(7);
      check("clr_edge7_state", 32'(state), 1);
      check("clr_edge7_clear", 32'(clear), 0);
      cyc(1);
      check("clr_state", 32'(state), 0);
      check("clr_pulse", 32'(clear), 1);
      check("clr_count_en", 32'(count_en), 0);
      check("clr_led_run", 32'(led_run), 0);
      check("clr_presc", 32'(dut.presc), 0);
      ticks = 0;
      clears = 0;
      for (int i = 0; i < 12; i++) begin
         cyc(1);
         if (tick === 1'b1) ticks++;
         if (clear === 1'b1) clears++;
      end
      check("clr_single_cycle", 32'(clears), 0);
      check("clr_no_tick", 32'(ticks), 0);
      check("clr_state_held", 32'(state), 0);

      // Reset mid-LAP with display held low through and after reset.
      ks = 1'b0;
      fork begin cyc(10); ks = 1'b1; end join_none
      cyc(8);
      check("rerun_state", 32'(state), 1);
      cyc(10);
      kd = 1'b0;
      cyc(8);
      check("relap_state", 32'(state), 3);
      cyc(3);
      reset = 1'b1;
      cyc(1);
      check("mid_rst_state", 32'(state), 0);
      check("mid_rst_count_en", 32'(count_en), 0);
      check("mid_rst_tick", 32'(tick), 0);
      check("mid_rst_clear", 32'(clear), 0);
      check("mid_rst_display_live", 32'(display_live), 1);
      check("mid_rst_led_run", 32'(led_run), 0);
      check("mid_rst_led_disp", 32'(led_disp), 1);
      check("mid_rst_presc", 32'(dut.presc), 0);
      reset = 1'b0;
      cyc(10);
      ks = 1'b0;
      fork begin cyc(10); ks = 1'b1; end join_none
      cyc(8);
      check("post_rst_run", 32'(state), 1);
      cyc(15);
      check("held_disp_ignored", 32'(state), 1);
      check("held_disp_live", 32'(display_live), 1);
      kd = 1'b1;
      cyc(10);
      kd = 1'b0;
      fork begin cyc(10); kd = 1'b1; end join_none
      cyc(7);
      check("rearm_edge7_state", 32'(state), 1);
      cyc(1);
      check("rearm_lap_state", 32'(state), 3);
      check("rearm_display_live", 32'(display_live), 0);
      cyc(12);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
